// File: rtl/philv_imem_loader_if.sv
// Byte-stream ingress and instruction-memory write port of the program loader.
// The master side is the host/bench; the slave side is the loader.
interface philv_imem_loader_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
);
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [N-1:0]      imem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/philv_imem_loader.sv
// Loads a length-prefixed, XOR-checksummed little-endian word image into
// instruction memory and holds the core in reset until the image verifies.
module philv_imem_loader #(
  parameter int N      = 32,
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rstb,
  philv_imem_loader_if.slave  bus,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_loaded
);

  typedef enum logic [2:0] {HDR, LOAD, CSUM, DONE, ERR} state_e;

  localparam logic [N-1:0]  CAP = {{(N-ADDR_W-1){1'b0}}, 1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [N-1:0]        csum_q, csum_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N-1:0]        wdata_q, wdata_d;

  logic                accept;
  logic                word_done;
  logic [N-1:0]        word;

  assign accept    = bus.s_valid && bus.s_ready;
  assign word_done = accept && (cnt_q == 2'd3);
  // Byte 3 arrives on the bus, so the complete word is available in the accepting cycle.
  assign word      = {bus.s_data, asm_q};

  always_ff @(posedge clk) begin
    if (rstb) state_q <= HDR;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      cnt_q   <= '0;
      asm_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR: if (word_done) begin
        if (word == '0 || word > CAP) state_d = ERR;
        else                          state_d = LOAD;
      end
      LOAD: if (word_done && (idx_q + ONE == len_q)) state_d = CSUM;
      CSUM: if (word_done) state_d = (word == csum_q) ? DONE : ERR;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    len_d   = len_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    asm_d[7:0]   = bus.s_data;
        2'd1:    asm_d[15:8]  = bus.s_data;
        2'd2:    asm_d[23:16] = bus.s_data;
        default: asm_d        = asm_q;
      endcase
    end
    if (word_done && state_q == HDR) len_d = word[ADDR_W:0];
    if (word_done && state_q == LOAD) begin
      we_d    = 1'b1;
      addr_d  = idx_q[ADDR_W-1:0];
      wdata_d = word;
      csum_d  = csum_q ^ word;
      idx_d   = idx_q + ONE;
    end
  end

  always_comb begin
    bus.s_ready    = !rstb && (state_q == HDR || state_q == LOAD || state_q == CSUM);
    bus.imem_we    = we_q;
    bus.imem_addr  = addr_q;
    bus.imem_wdata = wdata_q;
    load_done      = (state_q == DONE);
    load_err       = (state_q == ERR);
    core_hold      = (state_q != DONE);
    words_loaded   = idx_q;
  end

endmodule

// File: tb/tb_philv_imem_loader.sv
// Directed bench for philv_imem_loader: table of whole-image loads plus
// hand-written sequences for the full-capacity image, mid-load reset and terminal states.
module tb_philv_imem_loader;
  localparam int N      = 32;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rstb;
  logic core_hold, load_done, load_err;
  logic [ADDR_W:0] words_loaded;

  philv_imem_loader_if #(.N(N), .ADDR_W(ADDR_W)) bus ();

  philv_imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rstb         (rstb),
    .bus          (bus.slave),
    .core_hold    (core_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data [0:1023];
  logic [7:0]  wr_addr [0:1023];
  int          wr_cnt = 0;

  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wr_addr[wr_cnt % 1024] = bus.imem_addr;
      wr_data[wr_cnt % 1024] = bus.imem_wdata;
      wr_cnt = wr_cnt + 1;
    end
  end

  logic [31:0] pay [0:255];

  typedef struct {
    string       name;
    logic [31:0] hdr;
    logic        body;
    logic        gaps;
    logic [31:0] csum;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
  } vec_t;

  vec_t vecs [0:5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b1;
    bus.s_valid = 1'b0;
    #1 chk("s_ready_in_reset", {63'd0, bus.s_ready}, 64'd0);
    @(negedge clk);
    rstb = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.s_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.s_ready !== 1'b1) begin
      chk("s_ready_timeout", {63'd0, bus.s_ready}, 64'd1);
    end else begin
      bus.s_valid = 1'b1;
      bus.s_data  = b;
      @(posedge clk);
      #1;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps) repeat ($urandom_range(1, 5)) @(negedge clk);
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    {63'd0, bus.imem_we}, 64'd0);
    chk({tag, "_addr"},  {56'd0, bus.imem_addr}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, bus.imem_wdata}, 64'd0);
    chk({tag, "_words"}, {55'd0, words_loaded}, 64'd0);
    chk({tag, "_done"},  {63'd0, load_done}, 64'd0);
    chk({tag, "_err"},   {63'd0, load_err}, 64'd0);
    chk({tag, "_hold"},  {63'd0, core_hold}, 64'd1);
    chk({tag, "_ready"}, {63'd0, bus.s_ready}, 64'd1);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    chk({tag, "_nwr"}, 64'(wr_cnt - base), 64'(n));
    for (int i = 0; i < n && i < 256; i++) begin
      chk({tag, "_wa"}, {56'd0, wr_addr[(base + i) % 1024]}, 64'(i));
      chk({tag, "_wd"}, {32'd0, wr_data[(base + i) % 1024]}, {32'd0, pay[i]});
    end
  endtask

  task automatic check_final(input string tag, input logic d, input logic e, input int nw);
    chk({tag, "_done"},  {63'd0, load_done}, {63'd0, d});
    chk({tag, "_err"},   {63'd0, load_err}, {63'd0, e});
    chk({tag, "_hold"},  {63'd0, core_hold}, {63'd0, !d});
    chk({tag, "_ready"}, {63'd0, bus.s_ready}, 64'd0);
    chk({tag, "_words"}, {55'd0, words_loaded}, 64'(nw));
  endtask

  task automatic load_nominal();
    pay[0] = 32'h0000_0013;
    pay[1] = 32'h0010_0093;
    pay[2] = 32'h0020_8113;
  endtask

  initial begin
    int base;
    logic [31:0] cs;
    rstb = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    load_nominal();

    vecs[0] = '{"nominal",    32'd3,          1'b1, 1'b0, 32'h0030_8193, 1'b1, 1'b0, 3};
    vecs[1] = '{"len_zero",   32'd0,          1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 0};
    vecs[2] = '{"len_257",    32'd257,        1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 0};
    vecs[3] = '{"len_hibits", 32'h0001_0003,  1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 0};
    vecs[4] = '{"bad_csum",   32'd3,          1'b1, 1'b0, 32'h0030_8192, 1'b0, 1'b1, 3};
    vecs[5] = '{"gaps",       32'd3,          1'b1, 1'b1, 32'h0030_8193, 1'b1, 1'b0, 3};

    repeat (2) @(negedge clk);
    do_reset();
    #1 check_reset_outputs("reset");

    for (int v = 0; v < 6; v++) begin
      do_reset();
      base = wr_cnt;
      send_word(vecs[v].hdr, vecs[v].gaps);
      if (!vecs[v].body)
        chk({vecs[v].name, "_err_next_cycle"}, {63'd0, load_err}, 64'd1);
      if (vecs[v].body) begin
        for (int i = 0; i < 3; i++) send_word(pay[i], vecs[v].gaps);
        chk({vecs[v].name, "_hold_before_csum"}, {63'd0, core_hold}, 64'd1);
        send_word(vecs[v].csum, vecs[v].gaps);
        chk({vecs[v].name, "_done_next_cycle"}, {63'd0, load_done}, {63'd0, vecs[v].exp_done});
      end
      repeat (2) @(negedge clk);
      check_writes(vecs[v].name, base, vecs[v].exp_words);
      check_final(vecs[v].name, vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_words);
    end

    // Nominal load, then bytes offered in DONE must be refused and nothing may move.
    do_reset();
    base = wr_cnt;
    send_word(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0);
    send_word(32'h0030_8193, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h5A;
    repeat (6) @(negedge clk);
    bus.s_valid = 1'b0;
    chk("done_refuse_nwr", 64'(wr_cnt - base), 64'd3);
    chk("done_hold_addr",  {56'd0, bus.imem_addr}, 64'd2);
    chk("done_hold_wdata", {32'd0, bus.imem_wdata}, 64'h0020_8113);
    check_final("done_refuse", 1'b1, 1'b0, 3);

    // Full-capacity image of 256 words.
    cs = 32'h0;
    for (int i = 0; i < 256; i++) begin
      pay[i] = 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
      cs = cs ^ pay[i];
    end
    do_reset();
    base = wr_cnt;
    send_word(32'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(pay[i], 1'b0);
    send_word(cs, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("cap256", base, 256);
    check_final("cap256", 1'b1, 1'b0, 256);

    // Reset after the second byte of the second payload word, then a clean reload.
    load_nominal();
    do_reset();
    send_word(32'd3, 1'b0);
    send_word(pay[0], 1'b0);
    send_byte(pay[1][7:0]);
    send_byte(pay[1][15:8]);
    do_reset();
    #1 check_reset_outputs("midreset");
    base = wr_cnt;
    send_word(32'd3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(pay[i], 1'b0);
    send_word(32'h0030_8193, 1'b0);
    repeat (2) @(negedge clk);
    check_writes("reload", base, 3);
    check_final("reload", 1'b1, 1'b0, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/philv_imem_loader.md
Name: philv_imem_loader

Overview:
- Program loader that fills the Philosophy-V core's instruction memory from an external byte stream and holds the core in reset until the image is complete and verified.
- Drives the stimulus into the core instead of observing it. Sits between a host byte source (UART/bench) and the instruction memory write port.
- Stream format: 32-bit length word L, then L instruction words, then a 32-bit XOR checksum word. All words are sent little-endian, one byte at a time.

Parameters:
- N, 32, instruction/word width in bits (fixed at 32; the byte assembler assumes 4 bytes per word)
- ADDR_W, 8, instruction memory word-address width; capacity is 2^ADDR_W words

Ports:
- clk  in  1  system clock, rising-edge
- rstb  in  1  reset: synchronous, active-high
- s_valid  in  1  byte-stream valid
- s_data  in  8  byte-stream data
- s_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word
- imem_addr  out  ADDR_W  word address for the write
- imem_wdata  out  N  instruction word for the write
- core_hold  out  1  1 = keep the core in reset
- load_done  out  1  sticky: image loaded and checksum matched
- load_err  out  1  sticky: bad length or checksum mismatch
- words_loaded  out  ADDR_W+1  count of words written so far

Behaviour:
- Reset (rstb=1 at a clk edge):
  - state=HDR, byte counter=0, word index=0, checksum accumulator=0.
  - imem_we=0, imem_addr=0, imem_wdata=0, words_loaded=0, load_done=0, load_err=0, core_hold=1.
  - s_ready is forced 0 while rstb=1.
  - Instruction memory contents are not cleared.
- Handshake:
  - A byte is accepted on a clk edge where s_valid && s_ready.
  - s_ready = !rstb && state in {HDR, LOAD, CSUM}. It is combinational from state and has no dependence on s_valid.
  - s_data is ignored when not accepted. Idle cycles between bytes are legal and change no state.
- Byte assembly:
  - A 2-bit byte counter selects the destination byte lane: byte k fills bits [8k+7:8k].
  - A word completes on acceptance of byte 3; the counter then wraps to 0.
- States:
  - HDR: on word complete, L = word.
    - If L==0 or L > 2^ADDR_W, go to ERR.
    - Otherwise latch L and go to LOAD.
  - LOAD: on each word complete:
    - imem_we=1 in the following cycle only, with imem_addr=word index[ADDR_W-1:0] and imem_wdata=word.
    - checksum ^= word; word index += 1; words_loaded += 1 in the same cycle as imem_we.
    - When word index reaches L, go to CSUM. The final write still pulses in that cycle.
  - CSUM: on word complete, compare against the checksum accumulator.
    - Equal: go to DONE.
    - Unequal: go to ERR.
    - The header and checksum words are excluded from the XOR.
  - DONE (terminal): load_done=1, core_hold=0, s_ready=0. Held until reset.
  - ERR (terminal): load_err=1, core_hold=1, s_ready=0. Held until reset; words_loaded keeps its final value.
- Output timing:
  - load_done, load_err and core_hold update in the cycle after the deciding byte is accepted.
  - load_done and load_err are never both 1.
  - imem_addr and imem_wdata hold their last written values between pulses.
- Boundaries:
  - L = 2^ADDR_W is legal; the final write goes to address 2^ADDR_W-1 and words_loaded = 2^ADDR_W (this is why the port is ADDR_W+1 bits wide).
  - A reset mid-word or mid-load discards partial bytes and returns to HDR with core_hold=1.
  - Bytes presented in DONE or ERR are not accepted, since s_ready=0.

Test Plan:
1. Nominal load, L=3, words 0x00000013, 0x00100093, 0x00208113, checksum 0x00308193; bytes e.g. 93 00 10 00 -> imem_we pulses at addr 0,1,2 with matching data; words_loaded=3; then load_done=1, core_hold=0, s_ready=0, load_err=0.
2. Header L=0 -> load_err=1 one cycle after the 4th header byte; no imem_we; core_hold=1; s_ready=0.
3. Header L=257 with ADDR_W=8 -> load_err=1; no writes. Separately, L=256 with correct checksum -> last write at addr 0xFF, words_loaded=256, load_done=1.
4. Test 1 stream with checksum 0x00308192 -> three writes occur, then load_err=1, load_done=0, core_hold stays 1, words_loaded=3.
5. Test 1 stream with s_valid deasserted for 1–5 random cycles between bytes -> identical write sequence and final outputs as test 1.
6. rstb=1 for one cycle after the 2nd byte of the 2nd payload word, then the full test 1 stream -> all outputs return to reset values, and the reload writes addr 0..2 and ends with load_done=1.
